// File: rtl/fetch_pkg.sv
// Shared fetch types and widths.
//   XLEN          : address width
//   ILEN          : instruction width
//   fetch_state_t : fetch controller states
package fetch_pkg;
   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DROP
   } fetch_state_t;
endpackage

// File: rtl/fetch_npc_mux.sv
// Next-PC selection: trap over redirect over sequential +4, word aligned.
//   trap_valid/trap_pc         : exception redirect (highest priority)
//   redirect_valid/redirect_pc : branch/jump redirect
//   current_pc                 : PC register output
//   next_pc                    : selected, aligned next PC
module fetch_npc_mux
   import fetch_pkg::*;
(
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] current_pc,
   output logic [XLEN-1:0] next_pc
);

   logic [XLEN-1:0] sel_pc;

   // Priority select, then clear the low two bits.
   always_comb begin
      if (trap_valid) begin
         sel_pc = trap_pc;
      end else if (redirect_valid) begin
         sel_pc = redirect_pc;
      end else begin
         sel_pc = current_pc + XLEN'(4);
      end
      next_pc = {sel_pc[XLEN-1:2], 2'b00};
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences the PC register and the imem port,
// one outstanding request at a time, buffering under stall and dropping
// responses made stale by a redirect.
//   clk, rst                    : clock, synchronous active-high reset
//   stall                       : hazard stall (holds PC and delivered inst)
//   trap_valid/trap_pc          : trap redirect
//   redirect_valid/redirect_pc  : branch/jump redirect
//   current_pc / next_pc        : PC register output / input
//   waiting                     : PC register hold request
//   imem_req/addr/ready         : request channel
//   imem_rvalid/rdata           : response channel
//   inst_valid/inst/inst_pc     : instruction to IF/ID
module fetch_ctrl
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] current_pc,
   output logic [XLEN-1:0] next_pc,
   output logic            waiting,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
);

   fetch_state_t    state;
   fetch_state_t    state_nxt;
   logic [ILEN-1:0] hold_inst;
   logic [XLEN-1:0] hold_pc;
   logic            hold_load;
   logic            redir;

   assign redir = trap_valid | redirect_valid;

   fetch_npc_mux u_npc_mux (
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .current_pc     (current_pc),
      .next_pc        (next_pc)
   );

   // State register and hold buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_inst <= '0;
         hold_pc   <= '0;
      end else begin
         state <= state_nxt;
         if (hold_load) begin
            hold_inst <= imem_rdata;
            hold_pc   <= current_pc;
         end
      end
   end

   // Next state and decoded outputs; inst/inst_pc show the hold buffer
   // except when a live response is passed straight through.
   always_comb begin
      state_nxt  = state;
      imem_req   = 1'b0;
      imem_addr  = current_pc;
      waiting    = 1'b1;
      inst_valid = 1'b0;
      inst       = hold_inst;
      inst_pc    = hold_pc;
      hold_load  = 1'b0;

      unique case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            imem_req = 1'b1;
            // A redirect in the accept cycle makes the accepted address stale.
            if (imem_ready) begin
               state_nxt = redir ? DROP : WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (redir) begin
                  state_nxt = REQ;
               end else begin
                  inst_valid = 1'b1;
                  inst       = imem_rdata;
                  inst_pc    = current_pc;
                  if (stall) begin
                     hold_load = 1'b1;
                     state_nxt = HOLD;
                  end else begin
                     waiting   = 1'b0;
                     state_nxt = REQ;
                  end
               end
            end else if (redir) begin
               state_nxt = DROP;
            end
         end
         HOLD: begin
            waiting = 1'b0;
            if (redir) begin
               state_nxt = REQ;
            end else begin
               inst_valid = 1'b1;
               if (!stall) begin
                  state_nxt = REQ;
               end
            end
         end
         DROP: begin
            if (imem_rvalid) begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A redirect always lets the PC register load the new target.
      if (redir) begin
         waiting = 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// stimulus, compared against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall;
   logic            trap_valid;
   logic [63:0]     trap_pc;
   logic            redirect_valid;
   logic [63:0]     redirect_pc;
   logic [63:0]     current_pc;
   logic [63:0]     next_pc;
   logic            waiting;
   logic            imem_req;
   logic [63:0]     imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;
   logic            inst_valid;
   logic [31:0]     inst;
   logic [63:0]     inst_pc;

   fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .current_pc     (current_pc),
      .next_pc        (next_pc),
      .waiting        (waiting),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Model: out of reset, request outstanding, outstanding is stale, inst held.
   logic        m_started, m_out, m_stale, m_held;
   logic [63:0] m_pc, m_hpc;
   logic [31:0] m_hbuf;
   logic        e_req, e_wait, e_iv;
   logic [31:0] e_inst;
   logic [63:0] e_ipc, e_npc;

   // Memory model and its configuration.
   logic        mb;
   int          md, rq_cnt;
   int          cfg_rdy_wait, cfg_rv_wait;
   bit          cfg_rand, cfg_fixed;
   logic [31:0] cfg_data;

   // Observations of the DUT from the last cycle and per-scenario tallies.
   logic        last_req, last_wait, last_iv;
   logic [31:0] last_inst;
   logic [63:0] last_ipc, last_addr, last_npc, iv_npc, iv_pc, first_addr;
   bit          have_addr;
   int          n_iv, n_adv, n_dead, n_addr_chg;
   logic [63:0] pc_log[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_iv = 0; n_adv = 0; n_dead = 0; n_addr_chg = 0; have_addr = 0;
      pc_log.delete();
   endtask

   task automatic model_eval();
      logic redir;
      redir  = trap_valid | redirect_valid;
      e_npc  = trap_valid ? trap_pc : (redirect_valid ? redirect_pc : m_pc + 64'd4);
      e_npc[1:0] = 2'b00;
      e_req  = 1'b0;
      e_iv   = 1'b0;
      e_inst = m_hbuf;
      e_ipc  = m_hpc;
      e_wait = !redir;
      if (!m_started) begin
         e_wait = !redir;
      end else if (m_held) begin
         e_iv   = !redir;
         e_wait = 1'b0;
      end else if (m_out) begin
         if (imem_rvalid && !m_stale && !redir) begin
            e_iv   = 1'b1;
            e_inst = imem_rdata;
            e_ipc  = m_pc;
            e_wait = stall;
         end
      end else begin
         e_req = 1'b1;
      end
   endtask

   task automatic model_update();
      logic redir;
      logic [63:0] old_pc;
      redir  = trap_valid | redirect_valid;
      old_pc = m_pc;
      if (rst) begin
         m_started = 0; m_out = 0; m_stale = 0; m_held = 0;
         m_pc = '0; m_hpc = '0; m_hbuf = '0;
         return;
      end
      if (!e_wait && !stall) m_pc = e_npc;
      if (!m_started) begin
         m_started = 1;
      end else if (m_held) begin
         if (redir || !stall) m_held = 0;
      end else if (m_out) begin
         if (imem_rvalid) begin
            if (!m_stale && !redir && stall) begin
               m_held = 1; m_hbuf = imem_rdata; m_hpc = old_pc;
            end
            m_out = 0; m_stale = 0;
         end else if (redir) begin
            m_stale = 1;
         end
      end else if (imem_ready) begin
         m_out = 1; m_stale = redir;
      end
   endtask

   task automatic mem_drive();
      imem_rvalid = mb && (md == 0);
      imem_rdata  = cfg_fixed ? cfg_data : 32'($urandom);
      if (cfg_rand) imem_ready = ($urandom_range(0, 2) != 0);
      else          imem_ready = (rq_cnt >= cfg_rdy_wait);
   endtask

   task automatic mem_update();
      if (rst) begin
         mb = 0; md = 0; rq_cnt = 0;
      end else if (imem_rvalid) begin
         mb = 0;
      end else if (mb) begin
         if (md > 0) md--;
      end else if (e_req) begin
         if (imem_ready) begin
            mb = 1; rq_cnt = 0;
            md = cfg_rand ? int'($urandom_range(0, 2)) : cfg_rv_wait;
         end else begin
            rq_cnt++;
         end
      end
   endtask

   task automatic run_cycle();
      assert (!((trap_valid || redirect_valid) && stall))
         else $fatal(1, "FAIL stimulus stall with redirect");
      #2;
      model_eval();
      last_req = imem_req; last_wait = waiting; last_iv = inst_valid;
      last_inst = inst; last_ipc = inst_pc; last_addr = imem_addr; last_npc = next_pc;
      if (!rst) begin
         chk("next_pc", next_pc, e_npc);
         chk("imem_req", 64'(imem_req), 64'(e_req));
         chk("waiting", 64'(waiting), 64'(e_wait));
         chk("inst_valid", 64'(inst_valid), 64'(e_iv));
         if (e_req) chk("imem_addr", imem_addr, m_pc);
         if (e_iv) begin
            chk("inst", 64'(inst), 64'(e_inst));
            chk("inst_pc", inst_pc, e_ipc);
         end
         if (inst_valid) begin
            n_iv++; pc_log.push_back(inst_pc); iv_npc = next_pc; iv_pc = inst_pc;
            if (inst == 32'hDEADBEEF) n_dead++;
         end
         if (!waiting && !stall) n_adv++;
         if (imem_req) begin
            if (have_addr && imem_addr != first_addr) n_addr_chg++;
            if (!have_addr) begin first_addr = imem_addr; have_addr = 1; end
         end
      end
      @(posedge clk);
      mem_update();
      model_update();
      #1;
      current_pc = m_pc;
   endtask

   task automatic step(input logic s, input logic tv, input logic [63:0] tpc,
                       input logic rv, input logic [63:0] rpc);
      mem_drive();
      stall = s; trap_valid = tv; trap_pc = tpc; redirect_valid = rv; redirect_pc = rpc;
      run_cycle();
   endtask

   initial begin
      rst = 1; stall = 0; trap_valid = 0; trap_pc = '0; redirect_valid = 0; redirect_pc = '0;
      current_pc = '0; imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
      mb = 0; md = 0; rq_cnt = 0;
      cfg_rand = 0; cfg_fixed = 1; cfg_data = 32'h00000013; cfg_rdy_wait = 0; cfg_rv_wait = 0;
      m_started = 0; m_out = 0; m_stale = 0; m_held = 0; m_pc = '0; m_hpc = '0; m_hbuf = '0;
      clr();

      // Reset, then zero-wait memory: one instruction every two cycles.
      step(0, 0, '0, 0, '0);
      rst = 0;
      step(0, 0, '0, 0, '0);
      chk("rst_req", 64'(last_req), 64'd0);
      chk("rst_waiting", 64'(last_wait), 64'd1);
      chk("rst_iv", 64'(last_iv), 64'd0);
      chk("rst_inst", 64'(last_inst), 64'd0);
      chk("rst_inst_pc", last_ipc, 64'd0);
      for (int i = 0; i < 8; i++) step(0, 0, '0, 0, '0);
      chk("zw_count", 64'(n_iv), 64'd4);
      if (pc_log.size() >= 3) begin
         chk("zw_pc0", pc_log[0], 64'h0);
         chk("zw_pc1", pc_log[1], 64'h4);
         chk("zw_pc2", pc_log[2], 64'h8);
      end

      // Slow memory: ready after 3 cycles, rvalid 2 cycles late.
      clr(); cfg_rdy_wait = 3; cfg_rv_wait = 2;
      for (int i = 0; i < 7; i++) step(0, 0, '0, 0, '0);
      chk("slow_pulses", 64'(n_iv), 64'd1);
      chk("slow_addr_stable", 64'(n_addr_chg), 64'd0);
      chk("slow_advances", 64'(n_adv), 64'd1);

      // Stall arriving with the response: held for three cycles.
      clr(); cfg_rdy_wait = 0; cfg_rv_wait = 0; cfg_data = 32'hDEADBEEF;
      step(0, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);
      chk("hold_no_adv", 64'(n_adv), 64'd0);
      step(0, 0, '0, 0, '0);
      chk("hold_dead", 64'(n_dead), 64'd4);
      chk("hold_adv", 64'(n_adv), 64'd1);

      // Redirect while waiting: response dropped, refetch at the target.
      clr(); cfg_rv_wait = 2; cfg_data = 32'h00000013;
      step(0, 0, '0, 0, '0);
      step(0, 0, '0, 1, 64'h1003);
      chk("redir_npc", last_npc, 64'h1000);
      step(0, 0, '0, 0, '0);
      step(0, 0, '0, 0, '0);
      step(0, 0, '0, 0, '0);
      chk("redir_no_iv", 64'(n_iv), 64'd0);
      chk("redir_req", 64'(last_req), 64'd1);
      chk("redir_addr", last_addr, 64'h1000);

      // Trap beats redirect.
      step(0, 1, 64'h8000, 1, 64'h2000);
      chk("trap_prio", last_npc, 64'h8000);
      step(0, 0, '0, 0, '0);
      step(0, 0, '0, 0, '0);

      // Sequential wrap at the top of the address space.
      clr(); cfg_rv_wait = 0;
      step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0);
      for (int i = 0; i < 10 && n_iv == 0; i++) step(0, 0, '0, 0, '0);
      chk("wrap_seen", 64'(n_iv), 64'd1);
      chk("wrap_npc", iv_npc, 64'h0);
      chk("wrap_inst_pc", iv_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // Reset in the middle of a transaction.
      cfg_rv_wait = 2;
      step(0, 0, '0, 0, '0);
      rst = 1;
      step(0, 0, '0, 0, '0);
      rst = 0;
      step(0, 0, '0, 0, '0);
      chk("mid_rst_req", 64'(last_req), 64'd0);
      chk("mid_rst_waiting", 64'(last_wait), 64'd1);
      chk("mid_rst_iv", 64'(last_iv), 64'd0);
      chk("mid_rst_inst", 64'(last_inst), 64'd0);
      chk("mid_rst_inst_pc", last_ipc, 64'd0);
      step(0, 0, '0, 0, '0);
      chk("mid_rst_req2", 64'(last_req), 64'd1);
      chk("mid_rst_addr", last_addr, 64'd0);

      // Random traffic against the model.
      cfg_rand = 1; cfg_fixed = 0;
      for (int i = 0; i < 3000; i++) begin
         logic tv, rv, s;
         rst = ($urandom_range(0, 99) == 0);
         tv  = ($urandom_range(0, 24) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         s   = (tv || rv) ? 1'b0 : ($urandom_range(0, 3) == 0);
         step(s, tv, {32'($urandom), 32'($urandom)}, rv, {32'($urandom), 32'($urandom)});
      end
      rst = 0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
